// File: rtl/regfile_ws_pkg.sv
// regfile_ws_pkg: shared widths and the queued write entry for the regfile write scheduler.
package regfile_ws_pkg;
    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;
    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } ws_entry_t;
endpackage

// File: rtl/ws_fifo.sv
// ws_fifo: dual-push single-pop in-order FIFO with a per-entry address match for hazard checks.
module ws_fifo
    import regfile_ws_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter int  AW      = AW_DEF,
    parameter type entry_t = ws_entry_t,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push1,
    input  logic             push2,
    input  entry_t           in1,
    input  entry_t           in2,
    input  logic             pop,
    input  logic [AW-1:0]    match_addr,
    output logic [CW-1:0]    count,
    output entry_t           head,
    output logic [DEPTH-1:0] match
);
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;

    // slot2 lands just behind slot1 when both push, otherwise at the tail
    always_comb begin
        mem_d = mem_q;
        if (push1) mem_d[wp_q] = in1;
        if (push2) mem_d[wp_q + PW'(push1)] = in2;
        wp_d    = wp_q + PW'(push1) + PW'(push2);
        rp_d    = rp_q + PW'(pop);
        count_d = count_q + CW'(push1) + CW'(push2) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q   <= '{default: '0};
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        logic [PW-1:0] off;
        assign off      = PW'(g) - rp_q;
        assign match[g] = (CW'(off) < count_q) && (mem_q[g].addr == match_addr);
    end

    assign count = count_q;
    assign head  = mem_q[rp_q];
endmodule

// File: rtl/regfile_write_sched.sv
// regfile_write_sched: queues writeback writes and round-robins them with load returns
// onto a single registered register-file write port.
module regfile_write_sched
    import regfile_ws_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int DROP_R0 = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    wb_write,
    input  logic [DW-1:0] wb_d1,
    input  logic [AW-1:0] wb_a1,
    input  logic [DW-1:0] wb_d2,
    input  logic [AW-1:0] wb_a2,
    output logic          wb_ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    output logic          err
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t           e1, e2, head;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] match;
    logic             push1, push2, q_elig, ld_elig, grant_q, grant_ld, ld_r0;
    logic             rf_we_q, rf_we_d, rr_last_q, rr_last_d, err_q, err_d;
    logic [AW-1:0]    rf_wa_q, rf_wa_d;
    logic [DW-1:0]    rf_wd_q, rf_wd_d;

    assign e1       = '{wb_a1, wb_d1};
    assign e2       = '{wb_a2, wb_d2};
    assign wb_ready = count <= CW'(DEPTH - 2);
    assign push1    = wb_ready && wb_write[0] && !(DROP_R0 != 0 && wb_a1 == '0);
    assign push2    = wb_ready && wb_write[1] && !(DROP_R0 != 0 && wb_a2 == '0);
    assign ld_r0    = DROP_R0 != 0 && ld_addr == '0;

    // entries pushed this edge are younger than the load, so only the old contents are matched
    assign q_elig   = count != '0;
    assign ld_elig  = ld_valid && !(|match);
    assign grant_q  = q_elig && (!ld_elig || rr_last_q);
    assign grant_ld = ld_elig && (!q_elig || !rr_last_q);
    assign ld_ready = grant_ld;

    ws_fifo #(.DEPTH(DEPTH), .AW(AW), .entry_t(entry_t)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push1      (push1),
        .push2      (push2),
        .in1        (e1),
        .in2        (e2),
        .pop        (grant_q),
        .match_addr (ld_addr),
        .count      (count),
        .head       (head),
        .match      (match)
    );

    always_comb begin
        rf_we_d   = 1'b0;
        rf_wa_d   = rf_wa_q;
        rf_wd_d   = rf_wd_q;
        rr_last_d = grant_ld ? 1'b1 : grant_q ? 1'b0 : rr_last_q;
        err_d     = err_q || (wb_write != 2'b00 && !wb_ready);
        if (grant_q) begin
            rf_we_d = 1'b1;
            rf_wa_d = head.addr;
            rf_wd_d = head.data;
        end else if (grant_ld && !ld_r0) begin
            rf_we_d = 1'b1;
            rf_wa_d = ld_addr;
            rf_wd_d = ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we_q   <= 1'b0;
            rf_wa_q   <= '0;
            rf_wd_q   <= '0;
            rr_last_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rf_we_q   <= rf_we_d;
            rf_wa_q   <= rf_wa_d;
            rf_wd_q   <= rf_wd_d;
            rr_last_q <= rr_last_d;
            err_q     <= err_d;
        end
    end

    assign rf_we = rf_we_q;
    assign rf_wa = rf_wa_q;
    assign rf_wd = rf_wd_q;
    assign err   = err_q;
endmodule

// File: tb/tb_regfile_write_sched.sv
// tb_regfile_write_sched: scenario tasks drive writeback/load traffic; a scoreboard
// queue holds the expected register-file write order checked on every rf_we.
module tb_regfile_write_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  wb_write = 2'b00;
    logic [31:0] wb_d1 = '0, wb_d2 = '0, ld_data = '0;
    logic [4:0]  wb_a1 = '0, wb_a2 = '0, ld_addr = '0;
    logic        ld_valid = 1'b0;
    logic        wb_ready, ld_ready, rf_we, err;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;
    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    regfile_write_sched dut (
        .clk(clk), .rst(rst), .wb_write(wb_write), .wb_d1(wb_d1), .wb_a1(wb_a1),
        .wb_d2(wb_d2), .wb_a2(wb_a2), .wb_ready(wb_ready), .ld_valid(ld_valid),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready), .rf_we(rf_we),
        .rf_wa(rf_wa), .rf_wd(rf_wd), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (rst && rf_we) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL rf_unexpected: actual wa=%0d wd=%h, required no write", rf_wa, rf_wd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rf_wa !== e.a || rf_wd !== e.d) begin
                    miscompares++;
                    $display("FAIL rf_write: actual wa=%0d wd=%h, required wa=%0d wd=%h",
                             rf_wa, rf_wd, e.a, e.d);
                end
            end
        end
    end

    task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: actual pending=%0d required pending=0", name, sb.size());
        end
        step();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        if (rf_we !== 1'b0) begin vectors++; miscompares++; $display("FAIL reset_we: actual=%b required=0", rf_we); end else vectors++;
        if (rf_wa !== 5'd0) begin vectors++; miscompares++; $display("FAIL reset_wa: actual=%0d required=0", rf_wa); end else vectors++;
        if (rf_wd !== 32'd0) begin vectors++; miscompares++; $display("FAIL reset_wd: actual=%h required=0", rf_wd); end else vectors++;
        if (err !== 1'b0) begin vectors++; miscompares++; $display("FAIL reset_err: actual=%b required=0", err); end else vectors++;
        if (wb_ready !== 1'b1) begin vectors++; miscompares++; $display("FAIL reset_wb_ready: actual=%b required=1", wb_ready); end else vectors++;
        if (ld_ready !== 1'b0) begin vectors++; miscompares++; $display("FAIL reset_ld_ready: actual=%b required=0", ld_ready); end else vectors++;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        push_exp(5, 32'hDEADBEEF);
        wb_write = 2'b01; wb_a1 = 5; wb_d1 = 32'hDEADBEEF;
        step();
        wb_write = 2'b00;
        @(negedge clk);
        if (rf_we !== 1'b0) begin vectors++; miscompares++; $display("FAIL single_early: actual=%b required=0", rf_we); end else vectors++;
        @(negedge clk);
        if (rf_we !== 1'b1) begin vectors++; miscompares++; $display("FAIL single_we: actual=%b required=1", rf_we); end else vectors++;
        @(negedge clk);
        if (rf_we !== 1'b0) begin vectors++; miscompares++; $display("FAIL single_once: actual=%b required=0", rf_we); end else vectors++;
        drain("single");
    endtask

    task automatic test_dual_same();
        push_exp(3, 1);
        push_exp(3, 2);
        wb_write = 2'b11; wb_a1 = 3; wb_d1 = 1; wb_a2 = 3; wb_d2 = 2;
        step();
        wb_write = 2'b00;
        drain("dual");
    endtask

    task automatic test_backpressure();
        logic bp_seen = 1'b0;
        for (int p = 0; p < 6; p++) begin
            for (int t = 0; t < 20 && !wb_ready; t++) begin
                bp_seen = 1'b1;
                wb_write = 2'b00;
                step();
            end
            wb_write = 2'b11;
            wb_a1 = 5'(2 * p + 1); wb_d1 = 32'(2 * p + 1);
            wb_a2 = 5'(2 * p + 2); wb_d2 = 32'(2 * p + 2);
            push_exp(wb_a1, wb_d1);
            push_exp(wb_a2, wb_d2);
            step();
        end
        wb_write = 2'b00;
        drain("bp");
        chk("bp_ready_dropped", 32'(bp_seen), 32'd1);
        chk("bp_err_clear", 32'(err), 32'd0);
        wb_write = 2'b11; wb_a1 = 13; wb_d1 = 13; wb_a2 = 14; wb_d2 = 14;
        push_exp(13, 13); push_exp(14, 14);
        step();
        wb_a1 = 15; wb_d1 = 15; wb_a2 = 16; wb_d2 = 16;
        push_exp(15, 15); push_exp(16, 16);
        step();
        chk("bp_full", 32'(wb_ready), 32'd0);
        wb_a1 = 20; wb_d1 = 20; wb_a2 = 21; wb_d2 = 21;
        step();
        wb_write = 2'b00;
        chk("err_set", 32'(err), 32'd1);
        drain("violation");
        chk("err_sticky", 32'(err), 32'd1);
    endtask

    task automatic test_round_robin();
        push_exp(7, 32'h70);
        push_exp(9, 32'h99);
        push_exp(8, 32'h80);
        wb_write = 2'b11; wb_a1 = 7; wb_d1 = 32'h70; wb_a2 = 8; wb_d2 = 32'h80;
        step();
        wb_write = 2'b00;
        step();
        ld_valid = 1'b1; ld_addr = 9; ld_data = 32'h99;
        @(negedge clk);
        chk("rr_grant", 32'(ld_ready), 32'd1);
        step();
        ld_valid = 1'b0;
        @(negedge clk);
        chk("rr_once", 32'(ld_ready), 32'd0);
        drain("rr");
    endtask

    task automatic test_hazard();
        push_exp(4, 32'hAA);
        push_exp(4, 32'hBB);
        wb_write = 2'b01; wb_a1 = 4; wb_d1 = 32'hAA;
        step();
        wb_write = 2'b00;
        ld_valid = 1'b1; ld_addr = 4; ld_data = 32'hBB;
        @(negedge clk);
        chk("hz_hold", 32'(ld_ready), 32'd0);
        step();
        @(negedge clk);
        chk("hz_grant", 32'(ld_ready), 32'd1);
        step();
        ld_valid = 1'b0;
        drain("hz");
    endtask

    task automatic test_r0_reset();
        wb_write = 2'b11; wb_a1 = 0; wb_d1 = 32'h123; wb_a2 = 0; wb_d2 = 32'h456;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("r0_count", 32'(wb_ready), 32'd1);
        end
        wb_write = 2'b00;
        repeat (2) @(negedge clk);
        chk("r0_no_we", 32'(rf_we), 32'd0);
        step();
        ld_valid = 1'b1; ld_addr = 0; ld_data = 32'h55;
        @(negedge clk);
        chk("ld_r0_ready", 32'(ld_ready), 32'd1);
        step();
        ld_valid = 1'b0;
        @(negedge clk);
        chk("ld_r0_we", 32'(rf_we), 32'd0);
        step();
        push_exp(10, 32'hA0);
        wb_write = 2'b11; wb_a1 = 10; wb_d1 = 32'hA0; wb_a2 = 11; wb_d2 = 32'hB0;
        step();
        wb_a1 = 12; wb_d1 = 32'hC0; wb_a2 = 13; wb_d2 = 32'hD0;
        step();
        wb_write = 2'b00;
        @(negedge clk);
        chk("rst_pre_we", 32'(rf_we), 32'd1);
        #1 rst = 1'b0;
        #1 chk("rst_async_we", 32'(rf_we), 32'd0);
        chk("rst_async_err", 32'(err), 32'd0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wb_ready", 32'(wb_ready), 32'd1);
        repeat (4) @(negedge clk);
        chk("rst_no_we", 32'(rf_we), 32'd0);
        chk("rst_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual_same();
        test_backpressure();
        test_round_robin();
        test_hazard();
        test_r0_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/regfile_write_sched.md
Name: regfile_write_sched

Overview:
Write-port scheduler placed between the writeback stage and a single-write-port register file. It accepts zero, one or two writes per cycle from writeback and buffers them in a small in-order queue. It also arbitrates a load-return requester onto the same port, issuing at most one register-file write per cycle. It provides backpressure to the pipeline and an address-hazard hold for loads.

Parameters:
DEPTH, 4, queue entries; power of 2, at least 2
AW, 5, register address width
DW, 32, data width
DROP_R0, 1, when 1, writes to address 0 are discarded at acceptance

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted at 0)
wb_write  in  2  bit0: slot1 valid; bit1: slot2 valid
wb_d1  in  DW  slot1 data
wb_a1  in  AW  slot1 address
wb_d2  in  DW  slot2 data
wb_a2  in  AW  slot2 address
wb_ready  out  1  writeback may present writes this cycle
ld_valid  in  1  load-return write request
ld_addr  in  AW  load destination address
ld_data  in  DW  load data
ld_ready  out  1  load granted this cycle
rf_we  out  1  register-file write enable (registered)
rf_wa  out  AW  register-file write address (registered)
rf_wd  out  DW  register-file write data (registered)
err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst=0, async): queue empty, count=0, rf_we=0, rf_wa=0, rf_wd=0, err=0, rr_last=0. wb_ready is 1. ld_ready is 0. All pending entries are lost.
- wb_ready = (count <= DEPTH-2). It is combinational from registered count and takes no credit for a same-cycle pop.
- Acceptance at edge k when wb_ready=1: push slot1 first, then slot2, each only if its valid bit is set. wb_write=2'b10 pushes slot2 only.
- Equal addresses in both slots: both entries are pushed in order, so the slot2 value is written last.
- DROP_R0=1: an entry with address 0 is not pushed and does not consume a slot.
- wb_write != 0 while wb_ready=0 is a violation: the writes are dropped and err is set to 1 until reset.
- Queue eligibility: count > 0.
- Load eligibility: ld_valid=1 and ld_addr matches no valid queue entry (hazard hold). Entries pushed at the same edge are younger and are not checked.
- Arbitration, evaluated each cycle:
  - Only one source eligible: it is granted.
  - Both eligible: grant the source other than rr_last (0 = queue granted last, 1 = load granted last).
  - rr_last is updated on every grant.
- ld_ready = load granted. It is combinational and valid in the same cycle as ld_valid.
- Issue at edge: the granted source loads rf_we=1, rf_wa, rf_wd. With no grant, rf_we=0 and rf_wa/rf_wd hold their values.
- A queue grant pops the head.
- DROP_R0=1 with ld_addr=0: the load is accepted (ld_ready=1) but rf_we stays 0.
- Latency: a writeback entry accepted at edge k appears on rf_* at edge k+1 at the earliest. A load granted in cycle k appears on rf_* at edge k.
- Simultaneous push(2) and pop(1): count += 1. Pointers wrap modulo DEPTH.
- Throughput: one rf write per cycle. Sustained dual writes are throttled by wb_ready.

Decomposition:
- Package regfile_ws_pkg: AW/DW defaults and an entry struct {addr[AW], data[DW]}.
- Sub-module ws_fifo: dual-push, single-pop FIFO. It exposes count, head, and a parallel address-match vector for the hazard check.
- Arbitration and output registers live in the top module.

Test Plan:
1. Single write. Present wb_write=01, a1=5, d1=0xDEADBEEF at edge 0. Expect rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF after edge 1, for exactly one cycle.
2. Dual write, same address. Present wb_write=11, a1=a2=3, d1=1, d2=2. Expect rf writes 3←1 then 3←2 on consecutive cycles.
3. Backpressure. Present wb_write=11 every cycle while wb_ready=1, with addresses 1..12 and data=addr. Expect wb_ready to drop when count>2, all 12 writes issued in order, and err=0. Then force a write with wb_ready=0: it is dropped and err=1.
4. Round-robin. Queue holds r7 and r8; ld_valid=1, ld_addr=9. Expect issue order r7, r9(load), r8, with ld_ready high for exactly one cycle.
5. Hazard. Queue holds r4=0xAA; load r4=0xBB. Expect ld_ready=0 until the queue entry pops, then rf writes r4←0xAA followed by r4←0xBB.
6. R0 and reset. Write wb a1=0: no rf_we and count unchanged. Drive rst=0 while count=3 and rf_we=1: rf_we=0 immediately, and wb_ready=1 after release.
